// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and external memory bus of the memory arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             i_req;
    logic [WIDTH-1:0] i_addr;
    logic [WIDTH-1:0] i_rdata;
    logic             i_ready;
    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic [WIDTH-1:0] d_rdata;
    logic             d_ready;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;
    logic             bus_err;
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch and data ports, with an unacknowledged-access watchdog.
// MEM_ARB_RR_EN selects round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
    state_t     state;
    logic [7:0] wd;
    logic       grant_d;
    logic       expire;
`ifdef MEM_ARB_RR_EN
    logic last_grant;
    always_comb grant_d = bus.d_req && !(bus.i_req && last_grant);
    always_ff @(posedge clock) begin
        if (reset) last_grant <= 1'b0;
        else if (state == IDLE && (bus.i_req || bus.d_req)) last_grant <= grant_d;
    end
`else
    always_comb grant_d = bus.d_req;
`endif
    // an ack in the final watchdog cycle still completes normally
    always_comb expire = !bus.mem_ack && wd == 8'(TIMEOUT - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            wd            <= 8'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {WIDTH{1'b0}};
            bus.mem_wdata <= {WIDTH{1'b0}};
            bus.i_ready   <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.i_rdata   <= {WIDTH{1'b0}};
            bus.d_rdata   <= {WIDTH{1'b0}};
            bus.bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_req || bus.d_req) begin
                    state        <= grant_d ? BUSY_D : BUSY_I;
                    bus.mem_req  <= 1'b1;
                    bus.mem_we   <= grant_d && bus.d_we;
                    bus.mem_addr <= grant_d ? bus.d_addr : bus.i_addr;
                    if (grant_d) bus.mem_wdata <= bus.d_wdata;
                end
                BUSY_I, BUSY_D: if (bus.mem_ack || expire) begin
                    state       <= DONE;
                    wd          <= 8'd0;
                    bus.mem_req <= 1'b0;
                    if (expire) bus.bus_err <= 1'b1;
                    if (state == BUSY_D) begin
                        bus.d_ready <= 1'b1;
                        bus.d_rdata <= expire ? {WIDTH{1'b0}} : bus.mem_rdata;
                    end else begin
                        bus.i_ready <= 1'b1;
                        bus.i_rdata <= expire ? {WIDTH{1'b0}} : bus.mem_rdata;
                    end
                end else begin
                    wd <= wd + 8'd1;
                end
                DONE: begin
                    state       <= IDLE;
                    bus.i_ready <= 1'b0;
                    bus.d_ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions on mem_arbiter, checked against a
// transaction-level model of grants, bus latency, watchdog and held read data.
module tb_mem_arbiter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    bit          last_d;
    bit          err_m;
    logic [31:0] i_rd_m;
    logic [31:0] d_rd_m;

    mem_arbiter_if #(.WIDTH(WIDTH)) bus ();
    mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL sim_timeout got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] outs();
        return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_ready, bus.d_ready,
                bus.i_rdata, bus.d_rdata, bus.bus_err};
    endfunction

    task automatic model_reset();
        err_m  = 1'b0;
        i_rd_m = '0;
        d_rd_m = '0;
        last_d = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(negedge clock);
            check("reset_outs", outs(), '0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    // Starts at a negedge in IDLE with requests set; returns at the negedge of the following IDLE.
    // Memory acks in busy cycle w (0-based); w >= TIMEOUT means it never acks.
    task automatic xfer(input int w, input logic [31:0] rd, output bit gd);
        int          n;
        logic [31:0] a;
        logic        we;
        logic [31:0] wdat;
        logic [31:0] exp_rd;
        gd     = (bus.i_req && bus.d_req) ? (RR ? !last_d : 1'b1) : bus.d_req;
        last_d = RR ? gd : last_d;
        a      = gd ? bus.d_addr : bus.i_addr;
        we     = gd && bus.d_we;
        wdat   = bus.d_wdata;
        n      = (w < TIMEOUT) ? w + 1 : TIMEOUT;
        exp_rd = (w < TIMEOUT) ? rd : 32'd0;
        err_m  = err_m || (w >= TIMEOUT);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check("busy_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_ready, bus.d_ready},
                  {1'b1, we, a, 2'b00});
            if (gd) check("busy_wdata", bus.mem_wdata, wdat);
            bus.mem_ack   = (k == w);
            bus.mem_rdata = (k == w) ? rd : $urandom;
        end
        @(negedge clock);
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        if (gd) d_rd_m = exp_rd;
        else i_rd_m = exp_rd;
        check("done_flags", {bus.mem_req, bus.i_ready, bus.d_ready, bus.bus_err}, {1'b0, !gd, gd, err_m});
        check("done_rdata", {bus.i_rdata, bus.d_rdata}, {i_rd_m, d_rd_m});
        @(negedge clock);
        check("idle", {bus.mem_req, bus.i_ready, bus.d_ready, bus.bus_err, bus.i_rdata, bus.d_rdata},
              {3'b000, err_m, i_rd_m, d_rd_m});
        if (gd) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
    endtask

    initial begin
        bit       g;
        int       w;
        logic [2:0] grants;
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h0000_0100;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0000_2000;
        bus.d_wdata   = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        model_reset();
        do_reset(2);
        for (int r = 0; r < 3; r++) begin
            xfer(0, $urandom, g);
            grants[2-r] = g;
            bus.i_req = 1'b1;
            bus.d_req = 1'b1;
        end
        check("grant_order", grants, RR ? 3'b101 : 3'b111);

        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        do_reset(1);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0100;
        xfer(0, 32'h0050_0093, g);
        check("fetch_rdata", bus.i_rdata, 32'h0050_0093);

        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_2000;
        bus.d_wdata = 32'hDEAD_BEEF;
        xfer(3, $urandom, g);

        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_3000;
        xfer(TIMEOUT - 1, 32'h1234_5678, g);
        check("ack_last_cycle_err", bus.bus_err, 1'b0);
        bus.d_req = 1'b1;
        xfer(TIMEOUT, 32'hFFFF_FFFF, g);
        check("timeout_err", {bus.bus_err, bus.d_rdata}, {1'b1, 32'h0});
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0200;
        xfer(1, $urandom, g);
        check("err_sticky", bus.bus_err, 1'b1);

        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h0000_4000;
        bus.mem_ack = 1'b0;
        @(negedge clock);
        check("rst_busy_req", bus.mem_req, 1'b1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_busy_outs", outs(), '0);
        reset     = 1'b0;
        bus.d_req = 1'b0;
        model_reset();
        @(negedge clock);
        check("rst_busy_idle", {bus.mem_req, bus.i_ready, bus.d_ready}, 3'b000);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0300;
        xfer(1, $urandom, g);

        repeat (150) begin
            if (!bus.i_req && $urandom_range(0, 1) == 1) begin
                bus.i_req  = 1'b1;
                bus.i_addr = $urandom;
            end
            if (!bus.d_req && $urandom_range(0, 1) == 1) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end
            if (!bus.i_req && !bus.d_req) begin
                bus.i_req  = 1'b1;
                bus.i_addr = $urandom;
            end
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            w = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, TIMEOUT - 1));
            xfer(w, $urandom, g);
            if ($urandom_range(0, 29) == 0) begin
                bus.mem_ack = 1'b0;
                do_reset(1);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the pipelined RV32 core. It shares one external memory bus between the instruction-fetch port and the data (load/store) port of the data path. Each port gets a registered request/ready handshake. The fetch and memory stages hold their request until `ready`, so a pending port stalls its stage. A watchdog aborts any bus transaction that is never acknowledged.

## Interface
Parameters:
- `WIDTH`, 32, address and data width.
- `TIMEOUT`, 16, maximum cycles `mem_req` may stay high without `mem_ack` before the transaction is aborted. Legal range 2..255.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held high until `i_ready`.
- `i_addr`  in  WIDTH  fetch address (the PC).
- `i_rdata`  out  WIDTH  fetched instruction; valid while `i_ready` is high.
- `i_ready`  out  1  one-cycle completion pulse for fetch.
- `d_req`  in  1  data request; held high until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  WIDTH  data address.
- `d_wdata`  in  WIDTH  store data.
- `d_rdata`  out  WIDTH  load data; valid while `d_ready` is high.
- `d_ready`  out  1  one-cycle completion pulse for data.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  WIDTH  bus address.
- `mem_wdata`  out  WIDTH  bus write data.
- `mem_rdata`  in  WIDTH  bus read data; sampled in the cycle `mem_ack` is high.
- `mem_ack`  in  1  bus acknowledge; may rise in the first cycle `mem_req` is high.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- **IDLE**
  - If `d_req` is high, latch `d_addr`, `d_we` and `d_wdata` into the `mem_*` registers and go to BUSY_D.
  - Otherwise, if `i_req` is high, latch `i_addr` with `mem_we` = 0 and go to BUSY_I.
  - Otherwise stay in IDLE.
- **BUSY_x**
  - `mem_req` = 1 and the `mem_*` outputs are held stable. Requester inputs are ignored.
  - On `mem_ack`: capture `mem_rdata` into `x_rdata`, clear the watchdog and go to DONE.
  - Stores also capture `mem_rdata`; its value is don't-care.
- **DONE**
  - `x_ready` = 1 for exactly this cycle and `mem_req` = 0. New requests are not sampled.
  - Next state is IDLE.
- `x_rdata` holds its value until the next completion on the same port.
- **Watchdog**
  - An 8-bit counter increments every BUSY cycle without `mem_ack`.
  - When it reaches `TIMEOUT`-1 with no ack in that cycle, the arbiter sets `bus_err`, loads `x_rdata` with 0, and goes to DONE with a normal `x_ready` pulse.
  - If `mem_ack` arrives in the same cycle the counter reaches `TIMEOUT`-1, the ack wins and `bus_err` is not set.
- `bus_err` clears only on reset.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `i_ready`, `d_ready` and `bus_err` = 0; `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` and the watchdog = 0.
- Minimum latency:
  - Request sampled at edge 0.
  - `mem_req` high during cycle 1; ack in cycle 1.
  - `ready` high during cycle 2.
  - Result: 2 cycles from request to ready, and one transaction every 3 cycles per bus.
- Each extra wait cycle on `mem_ack` adds one cycle of latency.
- A requester may drop or change its request in the cycle after its `ready` pulse. It may also keep it high to issue a new transaction, which is sampled in the following IDLE.
- Reset mid-transaction:
  - At the next edge the state returns to IDLE and `mem_req` drops.
  - The outstanding bus access is abandoned with no `ready` pulse.
  - The memory model must tolerate an abandoned request.
- A `mem_ack` seen while not in BUSY is ignored.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - A 1-bit `last_grant` register (reset to fetch) records the port most recently granted.
  - When `i_req` and `d_req` are both high in IDLE, the port not equal to `last_grant` is granted.
  - A single pending request is granted regardless of `last_grant`.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority; data always wins over fetch.
  - No `last_grant` register exists.

## Test plan
- **Reset:** assert `reset` 2 cycles with both requests high -> all outputs 0 during reset; the first grant follows the configured priority after release.
- **Single fetch, zero-wait memory:** `i_req`=1, `i_addr`=0x100, memory acks in the first cycle with 0x00500093 -> `mem_addr`=0x100 and `mem_we`=0 in cycle 1; `i_ready`=1 and `i_rdata`=0x00500093 in cycle 2.
- **Store with 3 wait states:** `d_req`=1, `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF -> `mem_req` high for 4 cycles with stable `mem_*` outputs; `d_ready` pulses once, 5 cycles after the request was sampled.
- **Simultaneous requests, 3 rounds:**
  - Without `MEM_ARB_RR_EN`: grant order D, D, D.
  - With it: grant order D, I, D.
- **Timeout:** `TIMEOUT`=4 with `mem_ack` tied to 0 -> after 4 BUSY cycles, `bus_err` rises and `d_ready` pulses with `d_rdata`=0; `bus_err` stays 1 until reset. Repeat with the ack in the 4th cycle -> `bus_err` stays 0.
- **Reset in BUSY_D:** assert `reset` during a wait state -> `mem_req`=0 at the next edge; no `d_ready` pulse; the FSM is in IDLE after reset is released.
